// File: rtl/page_walker.sv
// page_walker: radix page-table walker between the TLB miss path and the TLB insert path.
module page_walker #(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int NLEVEL = 3,
    parameter int SIDX   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req,
    output logic             miss_ready,
    input  logic [SADDR-1:0] miss_va,
    input  logic [SPCID-1:0] miss_pcid,
    input  logic [SADDR-1:0] root_pa,
    input  logic             abort,
    output logic             mem_req,
    output logic [SADDR-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [SADDR-1:0] mem_rdata,
    output logic             insert,
    output logic [SADDR-1:0] ins_va,
    output logic [SADDR-1:0] ins_pa,
    output logic [SPCID-1:0] ins_pcid,
    output logic             fault,
    output logic             busy
);
    localparam int LW = $clog2(NLEVEL);

    typedef enum logic [2:0] {IDLE, REQ, CHECK, DONE, FAULT, DRAIN} state_t;

    state_t           state, nxt;
    logic [SADDR-1:0] va_r, base, pte, pa_r;
    logic [SPCID-1:0] pcid_r;
    logic [LW-1:0]    level;
    logic [SIDX-1:0]  idx;
    logic [SADDR-1:0] ppn, lo_mask;

    assign idx     = SIDX'(va_r >> (SPAGE + SIDX * int'(level)));
    assign ppn     = pte & ~((SADDR'(1) << SPAGE) - SADDR'(1));
    // va bits a superpage at this level leaves untranslated; empty at level 0
    assign lo_mask = ((SADDR'(1) << (SIDX * int'(level))) - SADDR'(1)) << SPAGE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = miss_req ? REQ : IDLE;
            REQ:     nxt = mem_ack ? (abort ? IDLE : CHECK) : (abort ? DRAIN : REQ);
            CHECK:   nxt = abort ? IDLE :
                           !pte[0] ? FAULT :
                           pte[1] ? (|(ppn & lo_mask) ? FAULT : DONE) :
                           (level == '0) ? FAULT : REQ;
            DRAIN:   nxt = mem_ack ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            va_r   <= '0;
            pcid_r <= '0;
            base   <= '0;
            pte    <= '0;
            pa_r   <= '0;
            level  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && miss_req) begin
                va_r   <= miss_va;
                pcid_r <= miss_pcid;
                base   <= root_pa;
                level  <= LW'(NLEVEL - 1);
            end
            if (state == REQ && mem_ack)
                pte <= mem_rdata;
            if (state == CHECK && nxt == REQ) begin
                base  <= ppn;
                level <= level - 1'b1;
            end
            if (state == CHECK && nxt == DONE)
                pa_r <= ppn | (va_r & lo_mask);
        end
    end

    assign miss_ready = state == IDLE;
    assign busy       = state != IDLE;
    assign mem_req    = state == REQ || state == DRAIN;
    assign mem_addr   = mem_req ? base + (SADDR'(idx) << 3) : '0;
    assign insert     = state == DONE && !abort;
    assign fault      = state == FAULT && !abort;
    assign ins_va     = va_r;
    assign ins_pa     = pa_r;
    assign ins_pcid   = pcid_r;
endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: table-driven walks plus hand-written abort and mid-walk reset sequences.
module tb_page_walker;
    logic        clk = 0, rst_n = 0;
    logic        miss_req = 0, miss_ready, abort = 0;
    logic [63:0] miss_va = 0, root_pa = 0;
    logic [11:0] miss_pcid = 0;
    logic        mem_req, mem_ack;
    logic [63:0] mem_addr, mem_rdata;
    logic        insert, fault, busy;
    logic [63:0] ins_va, ins_pa;
    logic [11:0] ins_pcid;

    page_walker dut (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_ready(miss_ready),
        .miss_va(miss_va), .miss_pcid(miss_pcid), .root_pa(root_pa), .abort(abort),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .insert(insert), .ins_va(ins_va), .ins_pa(ins_pa), .ins_pcid(ins_pcid),
        .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] VA = 64'h40_2030_1ABC;

    logic [63:0] m1800 = 64'h2001, m2808 = 0, m3808 = 0;
    int wait_n = 0, wcnt = 0;
    int n_cmp = 0, n_bad = 0;
    int reads = 0, ins_cnt = 0, flt_cnt = 0, stab_err = 0;
    logic        pend = 0;
    logic [63:0] prev_addr = 0;

    assign mem_rdata = mem_addr == 64'h1800 ? m1800 :
                       mem_addr == 64'h2808 ? m2808 :
                       mem_addr == 64'h3808 ? m3808 : 64'h0;
    assign mem_ack = mem_req && wcnt >= wait_n;

    always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

    // request and address must not move while a read waits for its ack
    always @(negedge clk) begin
        if (pend && (!mem_req || mem_addr != prev_addr)) stab_err++;
        pend = mem_req && !mem_ack;
        prev_addr = mem_addr;
        if (mem_req && mem_ack) reads++;
        if (insert) ins_cnt++;
        if (fault) flt_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] l1, l0;
        int          wt;
        logic [11:0] pcid;
        logic        exp_ins;
        logic [63:0] exp_pa;
        int          exp_reads, exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic walk(input vec_t v);
        int r0, s0, cyc;
        m2808 = v.l1; m3808 = v.l0; wait_n = v.wt;
        r0 = reads; s0 = stab_err;
        @(negedge clk);
        chk({v.name, " ready"}, 64'(miss_ready), 64'h1);
        root_pa = 64'h1000; miss_va = VA; miss_pcid = v.pcid; miss_req = 1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        miss_req = 0;
        while (!insert && !fault && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " outcome_ins"}, 64'(insert), 64'(v.exp_ins));
        chk({v.name, " outcome_flt"}, 64'(fault), 64'(!v.exp_ins));
        chk({v.name, " latency"}, 64'(cyc), 64'(v.exp_lat));
        if (v.exp_ins) chk({v.name, " ins_pa"}, ins_pa, v.exp_pa);
        chk({v.name, " ins_va"}, ins_va, VA);
        chk({v.name, " ins_pcid"}, 64'(ins_pcid), 64'(v.pcid));
        chk({v.name, " reads"}, 64'(reads - r0), 64'(v.exp_reads));
        chk({v.name, " stable"}, 64'(stab_err - s0), 64'h0);
        @(negedge clk);
        chk({v.name, " pulse_end"}, 64'({insert, fault, miss_ready}), 64'b001);
    endtask

    initial begin
        vecs[0] = '{"hit3",      64'h3001,   64'h77003, 0, 12'h005, 1'b1, 64'h77000,  3, 7};
        vecs[1] = '{"superpage", 64'h200003, 64'h0,     0, 12'h0A5, 1'b1, 64'h301000, 2, 5};
        vecs[2] = '{"invalid",   64'h3000,   64'h77003, 0, 12'h123, 1'b0, 64'h0,      2, 5};
        vecs[3] = '{"misalign",  64'h201003, 64'h0,     0, 12'h456, 1'b0, 64'h0,      2, 5};
        vecs[4] = '{"l0_nonleaf",64'h3001,   64'h77001, 0, 12'hFFF, 1'b0, 64'h0,      3, 7};
        vecs[5] = '{"wait3",     64'h3001,   64'h77003, 3, 12'h005, 1'b1, 64'h77000,  3, 16};

        #12;
        chk("rst miss_ready", 64'(miss_ready), 64'h1);
        chk("rst strobes", 64'({insert, fault, mem_req, busy}), 64'h0);
        chk("rst mem_addr", mem_addr, 64'h0);
        chk("rst ins_va", ins_va, 64'h0);
        chk("rst ins_pa", ins_pa, 64'h0);
        chk("rst ins_pcid", 64'(ins_pcid), 64'h0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) walk(vecs[i]);

        begin : abort_seq
            int r0, i0, f0;
            m2808 = 64'h3001; m3808 = 64'h77003; wait_n = 3;
            r0 = reads; i0 = ins_cnt; f0 = flt_cnt;
            @(negedge clk);
            root_pa = 64'h1000; miss_va = VA; miss_pcid = 12'h7; miss_req = 1;
            @(negedge clk);
            miss_req = 0;
            chk("abort pre mem_req", 64'(mem_req), 64'h1);
            abort = 1;
            @(negedge clk);
            abort = 0;
            chk("abort drain mem_req", 64'(mem_req), 64'h1);
            chk("abort drain addr", mem_addr, 64'h1800);
            miss_req = 1; miss_va = 64'h0; miss_pcid = 12'h9;
            @(negedge clk);
            miss_req = 0;
            chk("abort busy", 64'(busy), 64'h1);
            repeat (12) @(negedge clk);
            chk("abort reads", 64'(reads - r0), 64'h1);
            chk("abort no insert", 64'(ins_cnt - i0), 64'h0);
            chk("abort no fault", 64'(flt_cnt - f0), 64'h0);
            chk("abort idle", 64'({miss_ready, busy}), 64'b10);
        end

        begin : reset_seq
            m2808 = 64'h3001; m3808 = 64'h77003; wait_n = 0;
            @(negedge clk);
            root_pa = 64'h1000; miss_va = VA; miss_pcid = 12'h3; miss_req = 1;
            @(posedge clk);
            @(negedge clk);
            miss_req = 0;
            @(negedge clk);
            chk("midcheck busy", 64'({busy, mem_req}), 64'b10);
            rst_n = 0;
            #1;
            chk("midrst strobes", 64'({insert, fault, mem_req, busy}), 64'h0);
            chk("midrst miss_ready", 64'(miss_ready), 64'h1);
            chk("midrst ins_va", ins_va, 64'h0);
            chk("midrst mem_addr", mem_addr, 64'h0);
            @(negedge clk);
            rst_n = 1;
            walk(vecs[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
